reg_write_bank: RTL and testbench

//  Write side of the 8x32 register bank; read selection is done by the 8:1 word mux.

---
 rtl/reg_write_bank_if.sv | 26 ++
 rtl/reg_write_bank.sv | 106 ++++++++++
 tb/tb_reg_write_bank.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_bank_if.sv
// Write/clear/readback bus of the 8x32 register bank.
// master: requester side (drives write requests and clear pulse).
// slave : the bank itself.
interface reg_write_bank_if #(
   parameter int WIDTH = 32
);
   logic                        wr_valid;
   logic                        wr_ready;
   logic [2:0]                  wr_addr;
   logic [WIDTH-1:0]            wr_data;
   logic [WIDTH/8-1:0]          wr_be;
   logic                        clr_req;
   logic                        busy;
   logic                        wr_done;
   logic [7:0][WIDTH-1:0]       rd_words;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_be, clr_req,
      input  wr_ready, busy, wr_done, rd_words
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_be, clr_req,
      output wr_ready, busy, wr_done, rd_words
   );
endinterface

// File: rtl/reg_write_bank.sv
// reg_write_bank: write side of the 8x32 register bank.
// One-entry write buffer (drains every cycle), byte-masked merge,
// sequenced one-register-per-cycle bank clear (IDLE/CLEAR FSM).
// Optional feature macro: REG_BANK_ZERO_REG_EN -- register 0 hardwired to 0.
module reg_write_bank #(
   parameter int NREGS = 8,
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            reset,
   reg_write_bank_if.slave bus
);
   localparam int NB = WIDTH / 8;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   typedef struct packed {
      logic [2:0]       addr;
      logic [WIDTH-1:0] data;
      logic [NB-1:0]    be;
   } wr_req_t;

   state_t                        state_q, state_d;
   logic [2:0]                    cnt_q, cnt_d;
   wr_req_t                       buf_q;
   logic                          buf_vld_q;
   logic [NREGS-1:0][WIDTH-1:0]   regs_q, regs_d;
   logic                          ready;
   logic                          accept;

   assign accept = bus.wr_valid && ready;

   // FSM state and clear counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: clr_req only honoured in IDLE, so a clear never restarts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: writes only accepted while idle
   always_comb begin
      ready    = (state_q == IDLE);
      bus.busy = (state_q == CLEAR);
   end

   assign bus.wr_ready = ready;

   // One-entry write buffer; it is emptied by the commit on the following edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_vld_q <= 1'b0;
         buf_q     <= '0;
      end else begin
         buf_vld_q <= accept;
         if (accept) buf_q <= '{addr: bus.wr_addr, data: bus.wr_data, be: bus.wr_be};
      end
   end

   // Register next state: buffered commit first, then clear, so a clear of the
   // same register on the same edge leaves it zero
   always_comb begin
      regs_d = regs_q;
      if (buf_vld_q) begin
         for (int b = 0; b < NB; b++) begin
            if (buf_q.be[b]) regs_d[buf_q.addr][8*b +: 8] = buf_q.data[8*b +: 8];
         end
      end
      if (state_q == CLEAR) regs_d[cnt_q] = '0;
`ifdef REG_BANK_ZERO_REG_EN
      regs_d[0] = '0;
`else
`endif
   end

   // Register bank storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) regs_q <= '0;
      else       regs_q <= regs_d;
   end

   assign bus.wr_done  = buf_vld_q;
   assign bus.rd_words = regs_q;
endmodule

// File: tb/tb_reg_write_bank.sv
// Directed testbench for reg_write_bank.
module tb_reg_write_bank;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   reg_write_bank_if #(.WIDTH(32)) bus ();

   reg_write_bank #(.NREGS(8), .WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // advance one rising edge, then settle so outputs are sampled off the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.wr_be    = '0;
      bus.clr_req  = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++;
      if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.wr_ready); end
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_vec++;
      if (bus.wr_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.wr_done); end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (bus.rd_words[i] !== 32'h0) begin n_err++; $display("FAIL reset_word%0d got=%h exp=0", i, bus.rd_words[i]); end
      end
   endtask

   task automatic test_single_write();
      bus.wr_valid = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 32'hAA0ED000; bus.wr_be = 4'hF;
      step();
      idle_inputs();
      n_vec++;
      if (bus.wr_done !== 1'b1) begin n_err++; $display("FAIL single_done got=%b exp=1", bus.wr_done); end
      n_vec++;
      if (bus.rd_words[3] !== 32'h0) begin n_err++; $display("FAIL single_early got=%h exp=0", bus.rd_words[3]); end
      step();
      n_vec++;
      if (bus.rd_words[3] !== 32'hAA0ED000) begin n_err++; $display("FAIL single_word3 got=%h exp=aa0ed000", bus.rd_words[3]); end
      n_vec++;
      if (bus.wr_done !== 1'b0) begin n_err++; $display("FAIL single_done_clr got=%b exp=0", bus.wr_done); end
      for (int i = 0; i < 8; i++) begin
         if (i != 3) begin
            n_vec++;
            if (bus.rd_words[i] !== 32'h0) begin n_err++; $display("FAIL single_other%0d got=%h exp=0", i, bus.rd_words[i]); end
         end
      end
   endtask

   task automatic test_byte_mask();
      bus.wr_valid = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 32'hA000000F; bus.wr_be = 4'hF;
      step();
      bus.wr_data = 32'h12345678; bus.wr_be = 4'b0011;
      step();
      idle_inputs();
      step();
      n_vec++;
      if (bus.rd_words[5] !== 32'hA0005678) begin n_err++; $display("FAIL mask_word5 got=%h exp=a0005678", bus.rd_words[5]); end
      // zero byte enables: handshake and wr_done still happen, register untouched
      bus.wr_valid = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 32'h0; bus.wr_be = 4'h0;
      step();
      idle_inputs();
      n_vec++;
      if (bus.wr_done !== 1'b1) begin n_err++; $display("FAIL be0_done got=%b exp=1", bus.wr_done); end
      step();
      n_vec++;
      if (bus.rd_words[3] !== 32'hAA0ED000) begin n_err++; $display("FAIL be0_word3 got=%h exp=aa0ed000", bus.rd_words[3]); end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) begin
         bus.wr_valid = 1'b1; bus.wr_addr = 3'(i); bus.wr_data = 32'h0100_0000 + 32'(i); bus.wr_be = 4'hF;
         n_vec++;
         if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got=%b exp=1", i, bus.wr_ready); end
         step();
         if (bus.wr_done === 1'b1) dones++;
      end
      idle_inputs();
      step();
      if (bus.wr_done === 1'b1) dones++;
      n_vec++;
      if (dones !== 8) begin n_err++; $display("FAIL b2b_dones got=%0d exp=8", dones); end
      for (int i = 0; i < 8; i++) begin
         exp = 32'h0100_0000 + 32'(i);
`ifdef REG_BANK_ZERO_REG_EN
         if (i == 0) exp = 32'h0;
`endif
         n_vec++;
         if (bus.rd_words[i] !== exp) begin n_err++; $display("FAIL b2b_word%0d got=%h exp=%h", i, bus.rd_words[i], exp); end
      end
   endtask

   task automatic test_clear();
      int cyc = 0;
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.busy !== 1'b1) break;
         cyc++;
         n_vec++;
         if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready_c%0d got=%b exp=0", cyc, bus.wr_ready); end
         // a second clr_req mid-clear must not restart the count
         bus.clr_req = (cyc == 3);
         step();
      end
      bus.clr_req = 1'b0;
      n_vec++;
      if (cyc !== 8) begin n_err++; $display("FAIL clr_cycles got=%0d exp=8", cyc); end
      n_vec++;
      if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready_end got=%b exp=1", bus.wr_ready); end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (bus.rd_words[i] !== 32'h0) begin n_err++; $display("FAIL clr_word%0d got=%h exp=0", i, bus.rd_words[i]); end
      end
   endtask

   task automatic test_clr_with_write();
      int waited = 0;
      bus.wr_valid = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'hF;
      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      n_vec++;
      if (bus.wr_done !== 1'b1) begin n_err++; $display("FAIL cw_done got=%b exp=1", bus.wr_done); end
      n_vec++;
      if (bus.busy !== 1'b1) begin n_err++; $display("FAIL cw_busy got=%b exp=1", bus.busy); end
      step();
      n_vec++;
      if (bus.rd_words[7] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL cw_commit got=%h exp=ffffffff", bus.rd_words[7]); end
      while (bus.busy === 1'b1 && waited < 20) begin step(); waited++; end
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL cw_timeout busy=%b exp=0", bus.busy); end
      n_vec++;
      if (bus.rd_words[7] !== 32'h0) begin n_err++; $display("FAIL cw_word7 got=%h exp=0", bus.rd_words[7]); end
   endtask

   task automatic test_reset_mid();
      // mid-clear reset: reg 6 still holds data when reset hits
      bus.wr_valid = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 32'h12345678; bus.wr_be = 4'hF;
      step();
      idle_inputs();
      step();
      n_vec++;
      if (bus.rd_words[6] !== 32'h12345678) begin n_err++; $display("FAIL rm_pre got=%h exp=12345678", bus.rd_words[6]); end
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      step(); step(); step();
      reset = 1'b1;
      #1;
      n_vec++;
      if (bus.rd_words[6] !== 32'h0) begin n_err++; $display("FAIL rm_clr_word6 got=%h exp=0", bus.rd_words[6]); end
      n_vec++;
      if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rm_clr_ready got=%b exp=1", bus.wr_ready); end
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_clr_busy got=%b exp=0", bus.busy); end
      reset = 1'b0;
      step();
      // reset with a buffered write pending: it must never commit
      bus.wr_valid = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
      step();
      idle_inputs();
      reset = 1'b1;
      #1;
      n_vec++;
      if (bus.wr_done !== 1'b0) begin n_err++; $display("FAIL rm_wr_done got=%b exp=0", bus.wr_done); end
      reset = 1'b0;
      step();
      n_vec++;
      if (bus.rd_words[4] !== 32'h0) begin n_err++; $display("FAIL rm_wr_word4 got=%h exp=0", bus.rd_words[4]); end
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_wr_busy got=%b exp=0", bus.busy); end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      step(); step();
      test_reset();
      reset = 1'b0;
      step();
      test_single_write();
      test_byte_mask();
      test_back_to_back();
      test_clear();
      test_clr_with_write();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
